// File: rtl/m68040_bus_pkg.sv
// Shared '040 bus encodings and the boot-ROM bridge state type.
package m68040_bus_pkg;

  // SIZ[1:0] transfer size encodings.
  typedef enum logic [1:0] {
    SizLong = 2'b00,
    SizByte = 2'b01,
    SizWord = 2'b10,
    SizLine = 2'b11
  } siz_e;

  // TT[1:0] transfer type encodings.
  typedef enum logic [1:0] {
    TtNormal = 2'b00,
    TtMove16 = 2'b01,
    TtAltAcc = 2'b10,
    TtIntAck = 2'b11
  } tt_e;

  typedef enum logic [2:0] {
    StWakeReq,
    StWakeAck,
    StWakeWait,
    StIdle,
    StFetch,
    StWait,
    StDrive,
    StErr
  } bridge_state_e;

endpackage

// File: rtl/flash_rom_bridge.sv
// 68040 boot-ROM window bridge: serves in-window reads (single or 4-beat line bursts)
// from an external SPI flash read engine, after issuing a wake command on the cfg port.
module flash_rom_bridge
  import m68040_bus_pkg::*;
#(
  parameter int unsigned             ADDR_BITS  = 24,
  parameter logic [ADDR_BITS-1:0]    FLASH_BASE = 24'h040000,
  parameter int unsigned             TAG_BITS   = 4,
  parameter logic [TAG_BITS-1:0]     WINDOW_TAG = 4'h0,
  parameter bit                      BURST_EN   = 1'b1,
  parameter logic [7:0]              WAKE_CMD   = 8'hAB,
  parameter int unsigned             WAKE_DELAY = 64,
  parameter int unsigned             TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          a,
  input  logic                 ts_n,
  input  logic                 rw,
  input  logic [1:0]           siz,
  output logic [31:0]          d_o,
  output logic                 d_oe_n,
  output logic                 ta_n,
  output logic                 tea_n,
  output logic                 tbi_n,
  output logic                 tci_n,
  output logic                 fl_cyc,
  output logic                 fl_stb,
  output logic [ADDR_BITS-3:0] fl_addr,
  input  logic                 fl_stall,
  input  logic                 fl_ack,
  input  logic [31:0]          fl_data,
  output logic                 cfg_cyc,
  output logic                 cfg_stb,
  output logic [7:0]           cfg_data,
  input  logic                 cfg_ack,
  output logic                 ready
);

  localparam int unsigned LwBits = ADDR_BITS - 2;
  localparam int unsigned CntMax = (TIMEOUT > WAKE_DELAY) ? TIMEOUT : WAKE_DELAY;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [LwBits-1:0] BaseLw      = LwBits'(FLASH_BASE >> 2);
  localparam logic [CntW-1:0]   WakeLast    = CntW'(WAKE_DELAY - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0]   CntSat      = {CntW{1'b1}};

  bridge_state_e state_q, state_d;

  logic [LwBits-1:0] req_lw_q, req_lw_d;
  logic              req_rw_q, req_rw_d;
  logic              req_line_q, req_line_d;
  logic              pend_q, pend_d;
  logic              line_nb_q, line_nb_d;
  logic [1:0]        beats_q, beats_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [31:0]       d_o_q, d_o_d;
  logic              d_oe_n_q, d_oe_n_d;
  logic              ta_n_q, ta_n_d;
  logic              tea_n_q, tea_n_d;
  logic              tbi_n_q, tbi_n_d;
  logic              fl_cyc_q, fl_cyc_d;
  logic              fl_stb_q, fl_stb_d;
  logic [LwBits-1:0] fl_addr_q, fl_addr_d;
  logic              cfg_cyc_q, cfg_cyc_d;
  logic              cfg_stb_q, cfg_stb_d;
  logic              ready_q, ready_d;

  logic in_window;
  logic unused_a;

  assign in_window = (a[31 -: TAG_BITS] == WINDOW_TAG);
  assign unused_a  = ^a;

  always_comb begin
    state_d    = state_q;
    req_lw_d   = req_lw_q;
    req_rw_d   = req_rw_q;
    req_line_d = req_line_q;
    pend_d     = pend_q;
    line_nb_d  = line_nb_q;
    beats_d    = beats_q;
    cnt_d      = cnt_q;
    d_o_d      = d_o_q;
    d_oe_n_d   = d_oe_n_q;
    ta_n_d     = ta_n_q;
    tea_n_d    = tea_n_q;
    tbi_n_d    = tbi_n_q;
    fl_cyc_d   = fl_cyc_q;
    fl_stb_d   = fl_stb_q;
    fl_addr_d  = fl_addr_q;
    cfg_cyc_d  = cfg_cyc_q;
    cfg_stb_d  = cfg_stb_q;
    ready_d    = ready_q;

    unique case (state_q)
      StWakeReq: begin
        if (!cfg_stb_q) begin
          cfg_cyc_d = 1'b1;
          cfg_stb_d = 1'b1;
        end else if (!fl_stall) begin
          cfg_stb_d = 1'b0;
          state_d   = StWakeAck;
        end
      end
      StWakeAck: begin
        if (cfg_ack) begin
          cfg_cyc_d = 1'b0;
          cnt_d     = '0;
          state_d   = StWakeWait;
        end
      end
      StWakeWait: begin
        if (cnt_q == WakeLast) begin
          ready_d = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (req_rw_q) begin
            fl_addr_d = BaseLw + req_lw_q;
            beats_d   = (req_line_q && BURST_EN) ? 2'd3 : 2'd0;
            line_nb_d = req_line_q && !BURST_EN;
            fl_cyc_d  = 1'b1;
            fl_stb_d  = 1'b1;
            cnt_d     = '0;
            state_d   = StFetch;
          end else begin
            tea_n_d = 1'b0;
            state_d = StErr;
          end
        end
      end
      StFetch: begin
        if (cnt_q != CntSat) cnt_d = cnt_q + 1'b1;
        if (!fl_stall) begin
          fl_stb_d = 1'b0;
          state_d  = StWait;
        end
      end
      StWait: begin
        // A late ack beats the timeout when both land in the same cycle.
        if (fl_ack) begin
          d_o_d    = fl_data;
          fl_cyc_d = 1'b0;
          ta_n_d   = 1'b0;
          d_oe_n_d = 1'b0;
          tbi_n_d  = !line_nb_q;
          state_d  = StDrive;
        end else if (cnt_q >= TimeoutLast) begin
          fl_cyc_d = 1'b0;
          fl_stb_d = 1'b0;
          tea_n_d  = 1'b0;
          state_d  = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrive: begin
        ta_n_d   = 1'b1;
        d_oe_n_d = 1'b1;
        tbi_n_d  = 1'b1;
        if (beats_q != 2'd0) begin
          // Critical word first: wrap within the 16-byte line.
          beats_d         = beats_q - 2'd1;
          fl_addr_d[1:0]  = fl_addr_q[1:0] + 2'd1;
          fl_cyc_d        = 1'b1;
          fl_stb_d        = 1'b1;
          cnt_d           = '0;
          state_d         = StFetch;
        end else begin
          state_d = StIdle;
        end
      end
      StErr: begin
        tea_n_d  = 1'b1;
        d_oe_n_d = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StWakeReq;
    endcase

    // Placed after the FSM so a TS on the consuming edge stays pending.
    if (!ts_n) begin
      req_lw_d   = a[ADDR_BITS-1:2];
      req_rw_d   = rw;
      req_line_d = (siz == SizLine);
      pend_d     = in_window;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StWakeReq;
      req_lw_q   <= '0;
      req_rw_q   <= 1'b0;
      req_line_q <= 1'b0;
      pend_q     <= 1'b0;
      line_nb_q  <= 1'b0;
      beats_q    <= 2'd0;
      cnt_q      <= '0;
      d_o_q      <= '0;
      d_oe_n_q   <= 1'b1;
      ta_n_q     <= 1'b1;
      tea_n_q    <= 1'b1;
      tbi_n_q    <= 1'b1;
      fl_cyc_q   <= 1'b0;
      fl_stb_q   <= 1'b0;
      fl_addr_q  <= '0;
      cfg_cyc_q  <= 1'b0;
      cfg_stb_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_lw_q   <= req_lw_d;
      req_rw_q   <= req_rw_d;
      req_line_q <= req_line_d;
      pend_q     <= pend_d;
      line_nb_q  <= line_nb_d;
      beats_q    <= beats_d;
      cnt_q      <= cnt_d;
      d_o_q      <= d_o_d;
      d_oe_n_q   <= d_oe_n_d;
      ta_n_q     <= ta_n_d;
      tea_n_q    <= tea_n_d;
      tbi_n_q    <= tbi_n_d;
      fl_cyc_q   <= fl_cyc_d;
      fl_stb_q   <= fl_stb_d;
      fl_addr_q  <= fl_addr_d;
      cfg_cyc_q  <= cfg_cyc_d;
      cfg_stb_q  <= cfg_stb_d;
      ready_q    <= ready_d;
    end
  end

  assign d_o      = d_o_q;
  assign d_oe_n   = d_oe_n_q;
  assign ta_n     = ta_n_q;
  assign tea_n    = tea_n_q;
  assign tbi_n    = tbi_n_q;
  assign tci_n    = 1'b1;
  assign fl_cyc   = fl_cyc_q;
  assign fl_stb   = fl_stb_q;
  assign fl_addr  = fl_addr_q;
  assign cfg_cyc  = cfg_cyc_q;
  assign cfg_stb  = cfg_stb_q;
  assign cfg_data = WAKE_CMD;
  assign ready    = ready_q;

endmodule

// File: tb/tb_flash_rom_bridge.sv
// Scoreboard bench: two bridges (burst on / burst off) share CPU stimulus, each with its own
// flash engine model; expected beats are queued at TS time and retired on each TA.
module tb_flash_rom_bridge;

  localparam logic [23:0] FLASH_BASE = 24'h040000;
  localparam logic [21:0] BASE_LW    = FLASH_BASE[23:2];
  localparam int          WAKE_DELAY = 8;
  localparam int          TIMEOUT    = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a;
  logic        ts_n, rw;
  logic [1:0]  siz;

  logic [31:0] d_o [2];
  logic [21:0] fl_addr [2];
  logic [31:0] fl_data [2];
  logic [7:0]  cfg_data [2];
  logic [1:0]  d_oe_n, ta_n, tea_n, tbi_n, tci_n, fl_cyc, fl_stb, cfg_cyc, cfg_stb, ready;
  logic [1:0]  fl_stall = '0;
  logic [1:0]  fl_ack   = '0;
  logic [1:0]  cfg_ack  = '0;

  flash_rom_bridge #(
    .ADDR_BITS(24), .FLASH_BASE(FLASH_BASE), .TAG_BITS(4), .WINDOW_TAG(4'h0), .BURST_EN(1'b1),
    .WAKE_CMD(8'hAB), .WAKE_DELAY(WAKE_DELAY), .TIMEOUT(TIMEOUT)
  ) u_dut0 (
    .clk(clk), .rst(rst), .a(a), .ts_n(ts_n), .rw(rw), .siz(siz), .d_o(d_o[0]),
    .d_oe_n(d_oe_n[0]), .ta_n(ta_n[0]), .tea_n(tea_n[0]), .tbi_n(tbi_n[0]), .tci_n(tci_n[0]),
    .fl_cyc(fl_cyc[0]), .fl_stb(fl_stb[0]), .fl_addr(fl_addr[0]), .fl_stall(fl_stall[0]),
    .fl_ack(fl_ack[0]), .fl_data(fl_data[0]), .cfg_cyc(cfg_cyc[0]), .cfg_stb(cfg_stb[0]),
    .cfg_data(cfg_data[0]), .cfg_ack(cfg_ack[0]), .ready(ready[0])
  );

  flash_rom_bridge #(
    .ADDR_BITS(24), .FLASH_BASE(FLASH_BASE), .TAG_BITS(4), .WINDOW_TAG(4'h0), .BURST_EN(1'b0),
    .WAKE_CMD(8'hAB), .WAKE_DELAY(WAKE_DELAY), .TIMEOUT(TIMEOUT)
  ) u_dut1 (
    .clk(clk), .rst(rst), .a(a), .ts_n(ts_n), .rw(rw), .siz(siz), .d_o(d_o[1]),
    .d_oe_n(d_oe_n[1]), .ta_n(ta_n[1]), .tea_n(tea_n[1]), .tbi_n(tbi_n[1]), .tci_n(tci_n[1]),
    .fl_cyc(fl_cyc[1]), .fl_stb(fl_stb[1]), .fl_addr(fl_addr[1]), .fl_stall(fl_stall[1]),
    .fl_ack(fl_ack[1]), .fl_data(fl_data[1]), .cfg_cyc(cfg_cyc[1]), .cfg_stb(cfg_stb[1]),
    .cfg_data(cfg_data[1]), .cfg_ack(cfg_ack[1]), .ready(ready[1])
  );

  typedef struct {
    int          inst;
    logic [21:0] addr;
    logic        tbi;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fdata(input logic [21:0] ad);
    return 32'hC0DE_0000 ^ {10'h155, ad};
  endfunction

  function automatic logic [21:0] exp_addr(input logic [31:0] ad, input int beat);
    logic [21:0] s;
    logic [1:0]  b;
    s      = BASE_LW + ad[23:2];
    b      = beat[1:0];
    s[1:0] = s[1:0] + b;
    return s;
  endfunction

  // Engine model, cfg responder and output monitor, all working at the falling edge.
  logic        ack_en = 1'b1;
  logic        stall_en = 1'b1;
  logic [1:0]  busy = '0, acked = '0, ta_low_prev = '0, cyc_prev = '0, cfgs_prev = '0;
  int          lat [2];
  logic [21:0] bus_addr [2];
  int          ack_cyc [2];
  int          ta_cnt [2], tea_cnt [2], cyc_rise [2], cfg_req [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      ta_cnt[i] = 0; tea_cnt[i] = 0; cyc_rise[i] = 0; cfg_req[i] = 0; ack_cyc[i] = 0;
      lat[i] = 0; fl_data[i] = '0; bus_addr[i] = '0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ta_n[i] === 1'b0) begin
        int idx;
        idx = -1;
        ta_cnt[i]++;
        check_eq("ta_width", ta_low_prev[i], 1'b0);
        for (int k = 0; k < exp_q.size(); k++)
          if (idx < 0 && exp_q[k].inst == i) idx = k;
        if (idx < 0) begin
          check_eq("ta_unexpected", ta_n[i], 1'b1);
        end else begin
          check_eq($sformatf("d_o%0d", i), d_o[i], fdata(exp_q[idx].addr));
          check_eq($sformatf("tbi_n%0d", i), tbi_n[i], exp_q[idx].tbi);
          check_eq("d_oe_n", d_oe_n[i], 1'b0);
          exp_q.delete(idx);
        end
      end
      if (tea_n[i] === 1'b0) tea_cnt[i]++;
      if (fl_cyc[i] && !cyc_prev[i]) cyc_rise[i]++;
      if (cfg_stb[i] && !cfgs_prev[i]) begin
        cfg_req[i]++;
        check_eq("cfg_data", cfg_data[i], 8'hAB);
      end
      ta_low_prev[i] = (ta_n[i] === 1'b0);
      cyc_prev[i]    = fl_cyc[i];
      cfgs_prev[i]   = cfg_stb[i];

      fl_ack[i]  = 1'b0;
      cfg_ack[i] = 1'b0;
      if (rst) begin
        busy[i]     = 1'b0;
        acked[i]    = 1'b0;
        fl_stall[i] = 1'b0;
      end else begin
        if (busy[i]) begin
          if (lat[i] == 0) begin
            busy[i] = 1'b0;
            if (ack_en) begin
              fl_ack[i]  = 1'b1;
              fl_data[i] = fdata(bus_addr[i]);
            end
          end else begin
            lat[i]--;
          end
        end
        fl_stall[i] = 1'b0;
        if (fl_cyc[i] && fl_stb[i] && !busy[i]) begin
          fl_stall[i] = (i == 0 && stall_en) ? ($urandom_range(0, 2) == 0) : 1'b0;
          if (!fl_stall[i]) begin
            busy[i]     = 1'b1;
            lat[i]      = 1;
            bus_addr[i] = fl_addr[i];
          end
        end
        if (cfg_cyc[i] && !cfg_stb[i] && !acked[i]) begin
          cfg_ack[i] = 1'b1;
          acked[i]   = 1'b1;
          ack_cyc[i] = cyc;
        end
      end
    end
  end

  // Drive one TS at the current falling edge; queue expected beats when data is expected.
  task automatic ts_go(input logic [31:0] ad, input logic r, input logic [1:0] s,
                       input bit expect_data);
    ts_n = 1'b0; a = ad; rw = r; siz = s;
    if (expect_data && ad[31:28] == 4'h0 && r) begin
      for (int i = 0; i < 2; i++) begin
        bit line;
        int nb;
        line = (s == 2'b11);
        nb   = (line && i == 0) ? 4 : 1;
        for (int b = 0; b < nb; b++)
          exp_q.push_back('{inst: i, addr: exp_addr(ad, b), tbi: !(line && i == 1)});
      end
    end
    @(negedge clk);
    ts_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq(tag, {ta_n[i], tea_n[i], tbi_n[i], tci_n[i], d_oe_n[i], fl_cyc[i], fl_stb[i],
                     cfg_cyc[i], cfg_stb[i], ready[i]}, 10'b11111_00000);
      check_eq({tag, "_d_o"}, d_o[i], 32'h0);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready[0] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, ready[0], 1'b1);
  endtask

  int t0, t1, e0, e1, c0, c1, n0, rdy_cyc;

  initial begin
    rst = 1'b1; ts_n = 1'b1; a = '0; rw = 1'b1; siz = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;

    // Wake handshake, with a TS issued while still waking.
    n0 = 0;
    while (!(acked[0] && acked[1]) && n0 < 50) begin
      @(negedge clk);
      n0++;
    end
    check_eq("wake_ack", acked, 2'b11);
    check_eq("not_ready_yet", ready[0], 1'b0);
    ts_go(32'h0000_0010, 1'b1, 2'b00, 1'b1);
    wait_ready("wake_ready");
    rdy_cyc = cyc;
    check_eq("wake_delay", rdy_cyc - ack_cyc[0], WAKE_DELAY + 1);
    check_eq("cfg_reqs", cfg_req[0], 1);
    drain();

    // Long read latency and address.
    ts_go(32'h0000_0010, 1'b1, 2'b00, 1'b1);
    check_eq("stb_early", fl_stb[0], 1'b0);
    @(negedge clk);
    check_eq("stb_latency", fl_stb[0], 1'b1);
    check_eq("fl_addr_long", fl_addr[0], 22'h010004);
    drain();

    // Line read: 4 beats with bursts, 1 inhibited beat without.
    t0 = ta_cnt[0]; t1 = ta_cnt[1];
    ts_go(32'h0000_0008, 1'b1, 2'b11, 1'b1);
    drain();
    check_eq("burst_beats", ta_cnt[0] - t0, 4);
    check_eq("nb_beats", ta_cnt[1] - t1, 1);

    // Byte read, and a word read whose flash address wraps.
    ts_go(32'h0000_0024, 1'b1, 2'b01, 1'b1);
    drain();
    ts_go(32'h00FF_FFF0, 1'b1, 2'b10, 1'b1);
    drain();

    for (int k = 0; k < 6; k++) begin
      logic [31:0] ra;
      logic [1:0]  rs;
      ra = $urandom() & 32'h0FFF_FFFF;
      rs = 2'($urandom_range(0, 3));
      ts_go(ra, 1'b1, rs, 1'b1);
      drain();
    end

    // Write hit: one TEA, no flash cycle.
    e0 = tea_cnt[0]; e1 = tea_cnt[1]; c0 = cyc_rise[0]; c1 = cyc_rise[1];
    ts_go(32'h0000_0020, 1'b0, 2'b00, 1'b1);
    repeat (6) @(negedge clk);
    check_eq("write_tea", tea_cnt[0] - e0, 1);
    check_eq("write_tea1", tea_cnt[1] - e1, 1);
    check_eq("write_no_cyc", cyc_rise[0] - c0, 0);

    // Out-of-window TS: nothing happens.
    t0 = ta_cnt[0]; e0 = tea_cnt[0]; c0 = cyc_rise[0];
    ts_go(32'h1000_0000, 1'b1, 2'b00, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("oow_ta", ta_cnt[0] - t0, 0);
    check_eq("oow_tea", tea_cnt[0] - e0, 0);
    check_eq("oow_cyc", cyc_rise[0] - c0, 0);

    // Withheld ack: TEA exactly TIMEOUT cycles after the strobe rises.
    ack_en = 1'b0; stall_en = 1'b0;
    ts_go(32'h0000_0040, 1'b1, 2'b00, 1'b0);
    repeat (TIMEOUT) @(negedge clk);
    check_eq("tea_early", tea_n[0], 1'b1);
    check_eq("cyc_held", fl_cyc[0], 1'b1);
    @(negedge clk);
    check_eq("tea_timeout", tea_n[0], 1'b0);
    check_eq("tea_timeout1", tea_n[1], 1'b0);
    check_eq("timeout_cyc_drop", fl_cyc[0], 1'b0);
    check_eq("timeout_no_ta", ta_n[0], 1'b1);
    @(negedge clk);
    check_eq("tea_width", tea_n[0], 1'b1);
    repeat (3) @(negedge clk);

    // Reset while waiting on the engine, then the wake sequence again.
    ts_go(32'h0000_0044, 1'b1, 2'b00, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("mid_wait_cyc", fl_cyc[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outs("mid_reset");
    rst = 1'b0; ack_en = 1'b1; stall_en = 1'b1;
    wait_ready("rewake_ready");
    check_eq("rewake_cfg_reqs", cfg_req[0], 2);

    t0 = ta_cnt[0];
    ts_go(32'h0000_010C, 1'b1, 2'b11, 1'b1);
    drain();
    check_eq("final_burst", ta_cnt[0] - t0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flash_rom_bridge.md
# flash_rom_bridge

Parametrised 68040 boot-ROM bridge: decodes a configurable address window on the '040 bus and serves reads from SPI flash through an external SPI read engine on a Wishbone-style port. It generalises the single-longword flash reader with line-burst support, a configurable window, base and wake sequence, write rejection, and an ack timeout. It sits between the CPU bus pins and the SPI flash reader in the board glue FPGA.

## Interface
Parameters:
- `ADDR_BITS`, 24: flash byte-address width.
- `FLASH_BASE`, 24'h040000: flash byte offset of window address 0; must be a multiple of 4.
- `TAG_BITS`, 4: number of `a` MSBs compared against `WINDOW_TAG`.
- `WINDOW_TAG`, 4'h0: value of `a[31:32-TAG_BITS]` that selects the window.
- `BURST_EN`, 1: 1 = serve line reads as 4-beat bursts; 0 = assert `tbi_n` and return one beat.
- `WAKE_CMD`, 8'hAB: command byte sent on the cfg port after reset.
- `WAKE_DELAY`, 64: cycles to wait after the wake ack before `ready` rises.
- `TIMEOUT`, 1024: cycles allowed for `fl_ack` before the cycle is terminated with TEA.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `a` in 32: '040 address.
- `ts_n` in 1: transfer start.
- `rw` in 1: 1 = read.
- `siz` in 2: transfer size; 2'b11 = line.
- `d_o` out 32: read data.
- `d_oe_n` out 1: data buffer output enable.
- `ta_n` out 1: transfer acknowledge.
- `tea_n` out 1: transfer error.
- `tbi_n` out 1: burst inhibit.
- `tci_n` out 1: cache inhibit; constant 1.
- `fl_cyc`, `fl_stb` out 1: flash bus cycle and strobe.
- `fl_addr` out `ADDR_BITS-2`: longword address.
- `fl_stall`, `fl_ack` in 1: engine handshake.
- `fl_data` in 32: engine read data.
- `cfg_cyc`, `cfg_stb` out 1: config cycle and strobe.
- `cfg_data` out 8: config command byte.
- `cfg_ack` in 1: config acknowledge.
- `ready` out 1: wake complete.

## Operation
State machine states: WAKE_REQ, WAKE_ACK, WAKE_WAIT, IDLE, FETCH, WAIT, DRIVE, ERR.

Wake sequence:
- WAKE_REQ: drive `cfg_cyc`=`cfg_stb`=1 and `cfg_data`=`WAKE_CMD`. Hold `cfg_stb` until it is accepted (`fl_stall`-free single cycle), then go to WAKE_ACK.
- WAKE_ACK: on `cfg_ack`, drop `cfg_cyc` and go to WAKE_WAIT.
- WAKE_WAIT: count `WAKE_DELAY` cycles, then set `ready`=1 and go to IDLE.

Address capture:
- Whenever `ts_n`=0, latch `a`, `rw` and `siz`.
- A TS that arrives before `ready` is held pending and served on entry to IDLE.
- A TS whose address is outside the window is ignored (no outputs change).

IDLE:
- Read hit: `fl_addr` = (`FLASH_BASE`>>2) + `a[ADDR_BITS-1:2]`, modulo 2^(`ADDR_BITS`-2). Beat count = 4 if `siz`=11 and `BURST_EN`=1, else 1. Go to FETCH.
- Write hit: go to ERR.

FETCH:
- Assert `fl_cyc`=`fl_stb`=1.
- Keep `fl_stb` while `fl_stall`=1; deassert it the cycle after acceptance, then go to WAIT.

WAIT:
- On `fl_ack`: register `fl_data` into `d_o`, drop `fl_cyc`, go to DRIVE.
- If the timeout counter reaches `TIMEOUT`: drop `fl_cyc` and `fl_stb`, go to ERR.

DRIVE:
- `ta_n`=0 and `d_oe_n`=0 for exactly one cycle.
- If beats remain: advance `fl_addr[1:0]` by 1 (wrapping within the 16-byte line, critical word first) and return to FETCH.
- Otherwise go to IDLE.

ERR:
- `tea_n`=0 for one cycle, `d_oe_n`=1, then go to IDLE.

`tbi_n`:
- Driven 0 together with `ta_n` when the request is a line read and `BURST_EN`=0.
- 1 otherwise.

Byte and word reads return the full longword; the CPU selects the byte lanes.

## Timing
- Reset values: `ta_n`=`tea_n`=`tbi_n`=`tci_n`=`d_oe_n`=1; `fl_cyc`=`fl_stb`=`cfg_cyc`=`cfg_stb`=0; `ready`=0; `d_o`=0; state WAKE_REQ.
- Reset asserted mid-operation: all outputs take their reset values at the next edge, any pending TS is discarded, and the wake sequence reruns.
- Latency: `ts_n` sampled low at edge N → `fl_stb` high at N+1. `fl_ack` at edge M → `ta_n` low during M+1 only.
- Burst: the next `fl_stb` rises in the cycle after the `ta_n` beat.
- The timeout counter resets on every FETCH entry.
- `fl_ack` and timeout in the same cycle: `fl_ack` wins.

## Structure
- Put the state enum and the `siz`/`tt` encodings (the line size code) in a shared `m68040_bus_pkg`.
- Single module; no sub-module is needed. The SPI engine and the DDR SCK driver stay outside in the top level.

## Test plan
- Wake: release `rst` → one cfg cycle with `cfg_data`=8'hAB; `ready` rises `WAKE_DELAY` cycles after `cfg_ack`.
- Long read at `a`=32'h0000_0010 → `fl_addr`=22'h010004; `ta_n` low exactly one cycle with `d_o`=`fl_data`.
- Line read at `a`=32'h0000_0008, `BURST_EN`=1 → `fl_addr[1:0]` sequence 2,3,0,1 and four TA pulses. With `BURST_EN`=0 → one beat with `tbi_n`=0.
- Write hit (`rw`=0) → `tea_n` low for one cycle, no `fl_cyc`. Out-of-window TS at 32'h1000_0000 → no response.
- `fl_ack` withheld → `tea_n` pulses at `TIMEOUT`, `fl_cyc` drops; `rst` during WAIT → outputs reset next edge and wake repeats.
